// File: rtl/vga_fb_arbiter.sv
// ----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Owns the single-port frame-buffer RAM and shares it between three users:
//   * VGA scan-out reads   - absolute priority, one read every other pixel
//   * a pixel writer       - handshake wr_req / wr_ack
//   * a built-in clear     - fills the whole buffer with one colour
// The frame buffer is FB_W x FB_H and is shown at 2x scale, so one RAM read
// feeds two output pixels and two output lines share the same buffer row.
//
// Ports
//   clk, rst            pixel clock, synchronous active-high reset
//   valid,h_cnt,v_cnt   active-video flag and position from the timing gen
//   vsync               vertical sync (active low), used for frame_tick
//   wr_req/addr/data    writer request, held until wr_ack
//   wr_ack              write committed (or dropped if out of range) this cycle
//   clear_req/color     start a fill; colour is latched when the fill starts
//   clear_busy          fill in progress
//   clear_done          one-cycle pulse after the last fill write
//   frame_tick          one-cycle pulse following a vsync falling edge
//   mem_addr/we/wdata   RAM command, combinational
//   mem_rdata           RAM read data, one cycle after the address
//   rgb, rgb_valid      registered pixel to the DAC, aligned to valid + 2
// ----------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int FB_W = 320,
    parameter int FB_H = 240,
    parameter int DW   = 12,
    parameter int AW   = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [9:0]    h_cnt,
    input  logic [9:0]    v_cnt,
    input  logic          vsync,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clear_req,
    input  logic [DW-1:0] clear_color,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          frame_tick,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb,
    output logic          rgb_valid
);

    localparam int FB_SIZE = FB_W * FB_H;

    // Last address written by the fill engine.
    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_SIZE - 1);

    // Size compared one bit wider so that 2^AW == FB_SIZE does not wrap to 0.
    localparam logic [AW:0] FB_LIMIT = (AW + 1)'(FB_SIZE);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] clr_color;

    logic          display_slot;
    logic [AW-1:0] disp_addr;
    logic          wr_in_range;

    logic          slot_d;
    logic          valid_d;
    logic [DW-1:0] pix_reg;
    logic          vsync_d;

    // Even columns of active video are reserved for scan-out. Odd columns and
    // all blanking cycles are free for the writer or the fill engine.
    assign display_slot = valid & ~h_cnt[0];

    // 2x scaling: drop the LSB of both counters to find the buffer pixel.
    assign disp_addr = AW'(v_cnt >> 1) * AW'(FB_W) + AW'(h_cnt >> 1);

    assign wr_in_range = ({1'b0, wr_addr} < FB_LIMIT);

    // RAM command mux. Display reads win unconditionally; otherwise the FSM
    // state decides who owns the free cycle. During reset no write or ack is
    // issued so a pending request or an aborted fill cannot touch the RAM.
    // A clear request in IDLE takes precedence over a simultaneous writer
    // request, which is therefore left pending.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (display_slot) begin
            mem_addr = disp_addr;
        end else if (!rst) begin
            case (state)
                IDLE: begin
                    if (!clear_req && wr_req) begin
                        wr_ack = 1'b1;
                        if (wr_in_range) begin
                            mem_we    = 1'b1;
                            mem_addr  = wr_addr;
                            mem_wdata = wr_data;
                        end
                    end
                end
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_addr  = clr_cnt;
                    mem_wdata = clr_color;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // Fill-engine FSM. The counter only advances on free cycles, so stalls by
    // scan-out simply stretch the fill. clear_done is a registered pulse that
    // lands in the cycle after the final write. A reset mid-fill returns to
    // IDLE without producing clear_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_color  <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clr_color  <= clear_color;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!display_slot) begin
                        if (clr_cnt == LAST_ADDR) begin
                            state      <= IDLE;
                            clr_cnt    <= '0;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + AW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Scan-out pipeline. A read issued at cycle S returns data during S+1.
    // rgb is registered, so at the end of S+1 it takes the fresh RAM data
    // directly while pix_reg keeps the same value for the second (odd) pixel
    // at S+3. rgb is forced to zero whenever the delayed valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_d    <= 1'b0;
            valid_d   <= 1'b0;
            pix_reg   <= '0;
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            slot_d    <= display_slot;
            valid_d   <= valid;
            rgb_valid <= valid_d;
            if (slot_d) begin
                pix_reg <= mem_rdata;
            end
            if (!valid_d) begin
                rgb <= '0;
            end else if (slot_d) begin
                rgb <= mem_rdata;
            end else begin
                rgb <= pix_reg;
            end
        end
    end

    // Frame tick on the vsync falling edge. vsync_d resets high so a vsync
    // held low out of reset does not produce a spurious tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= vsync_d & ~vsync;
        end
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Owns the single-port frame-buffer RAM and shares it between VGA scan-out (reads) and a pixel writer (game or render logic).
- A built-in clear engine can also fill the whole buffer with one colour.
- Frame buffer is FB_W x FB_H at 2x scale; display reads have absolute priority, writer and clear use the remaining cycles.
- Sits between vga_controller (same pixel clock) and the RGB output registers.

Parameters:
- FB_W, 320, frame-buffer width in pixels (display width / 2)
- FB_H, 240, frame-buffer height in lines (display height / 2)
- DW, 12, pixel data width (4:4:4 RGB)
- AW, 17, RAM address width; must satisfy 2^AW >= FB_W*FB_H

Ports:
- clk  in  1  pixel clock, shared with vga_controller
- rst  in  1  synchronous active-high reset
- valid  in  1  active-video flag from timing generator
- h_cnt  in  10  pixel column, 0..639 when valid
- v_cnt  in  10  line number, 0..479 when valid
- vsync  in  1  vertical sync, active low
- wr_req  in  1  writer request; held until wr_ack
- wr_addr  in  AW  writer linear address (y*FB_W + x)
- wr_data  in  DW  writer pixel
- wr_ack  out  1  write committed this cycle (combinational)
- clear_req  in  1  start clear; sampled in IDLE only
- clear_color  in  DW  fill value; sampled when clear starts
- clear_busy  out  1  clear in progress
- clear_done  out  1  one-cycle pulse after the last clear write
- frame_tick  out  1  one-cycle pulse on vsync falling edge
- mem_addr  out  AW  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  DW  RAM write data (combinational)
- mem_rdata  in  DW  RAM read data; 1-cycle latency
- rgb  out  DW  pixel to DAC, registered
- rgb_valid  out  1  valid delayed 2 cycles, registered

Behaviour:
- Display slot: a cycle with valid=1 and h_cnt[0]=0.
  - mem_addr = (v_cnt>>1)*FB_W + (h_cnt>>1); mem_we=0.
  - Writer and clear are stalled during the slot.
- Free slot: any other cycle. Granted by FSM state.
- Read pipeline:
  - Display slot at cycle S.
  - mem_rdata is captured into pix_reg at the end of S+1.
  - rgb = pix_reg when rgb_valid=1, else 0.
  - rgb_valid = valid delayed 2 cycles.
  - Each read covers two output pixels (S+2, S+3). Downstream delays hsync/vsync by 2 cycles to align.
- FSM states: IDLE, CLEAR.
  - IDLE, free slot, wr_req=1:
    - wr_addr < FB_W*FB_H: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
    - Out-of-range address: wr_ack=1, mem_we=0 (write dropped).
  - wr_ack is never asserted in a display slot.
  - The writer must deassert wr_req, or present the next request, the cycle after ack.
  - IDLE, clear_req=1: go to CLEAR; latch clear_color; clr_cnt<=0; clear_busy<=1.
    - clear_req beats wr_req in the same cycle; no wr_ack that cycle.
  - CLEAR, free slot: mem_we=1, mem_addr=clr_cnt, mem_wdata=latched colour; clr_cnt++.
    - After writing FB_W*FB_H-1: go to IDLE next cycle, clear_busy<=0, clear_done=1 for one cycle.
  - CLEAR: wr_ack=0, wr_req held pending; clear_req ignored.
  - Idle free slot with no request: mem_we=0, mem_addr=0, mem_wdata=0.
- Clear duration per frame: 420000 cycles - 153600 display slots = 266400 free, >= 76800 needed, so a clear completes within one frame.
- frame_tick: vsync_d registered; pulse when vsync_d=1 && vsync=0.
- Reset, all registered outputs and state:
  - FSM=IDLE, clr_cnt=0, clear_busy=0, clear_done=0, frame_tick=0, vsync_d=1, pix_reg=0, rgb=0, rgb_valid=0, valid pipeline=0.
  - Reset mid-clear aborts the clear with no clear_done pulse.
  - Writer requests pending at reset are not acked that cycle.

Test Plan:
- Reset, then valid=1, h_cnt=4, v_cnt=6: mem_addr=3*320+2=962, mem_we=0; mem_rdata=0xABC at S+1 -> rgb=0xABC at S+2 and S+3, rgb_valid=1.
- wr_req with wr_addr=100, wr_data=0xF00 in a display slot (h_cnt=10): wr_ack=0; next cycle (h_cnt=11): mem_we=1, addr=100, wr_ack=1.
- wr_req with wr_addr=76800: wr_ack=1 in the first free slot, mem_we=0 throughout.
- clear_req with colour 0x00F during active video: 76800 writes, addresses 0..76799 strictly ascending, none in display slots; one clear_done pulse; concurrent wr_req acked only after clear_busy falls.
- rst asserted at clr_cnt=5000: next cycle clear_busy=0, FSM=IDLE, no clear_done; new clear_req restarts at address 0.
- Full-frame run with the timing generator: exactly one frame_tick per 420000 cycles, on vsync falling edge; rgb=0 whenever rgb_valid=0.
